// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the multi-channel clock divider.
//   CLKDIV_TOGGLE / CLKDIV_PULSE : per-channel mode encodings
//   CLKDIV_CNT_W                 : default counter/divisor width
package clkdiv_pkg;

  localparam logic        CLKDIV_TOGGLE = 1'b0;
  localparam logic        CLKDIV_PULSE  = 1'b1;
  localparam int unsigned CLKDIV_CNT_W  = 32;

  // Output level produced at a wrap: pulse mode strobes high, toggle mode inverts.
  function automatic logic clkdiv_wrap_level(input logic mode, input logic cur);
    return (mode == CLKDIV_PULSE) ? 1'b1 : ~cur;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// clkdiv_channel: one divider channel with shadowed divisor/mode.
//   CLOCK, RESET : rising-edge clock, synchronous active-high reset
//   align        : phase-align strobe (only with CLKDIV_PHASE_ALIGN_EN)
//   en           : count enable
//   m, mode      : requested divisor and mode, captured at reset/wrap/align
//   slow_clock   : divided output (registered)
//   tick         : one-cycle wrap strobe (registered)
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CLKDIV_CNT_W
) (
  input  logic             CLOCK,
  input  logic             RESET,
`ifdef CLKDIV_PHASE_ALIGN_EN
  input  logic             align,
`endif
  input  logic             en,
  input  logic [CNT_W-1:0] m,
  input  logic             mode,
  output logic             slow_clock,
  output logic             tick
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] m_act_q, m_act_d;
  logic             mode_act_q, mode_act_d;
  logic             slow_q, slow_d;
  logic             tick_q, tick_d;
  logic             wrap_c;

  // Next-state: hold when disabled, count up, or wrap and reload the shadow registers.
  always_comb begin
    count_d    = count_q;
    m_act_d    = m_act_q;
    mode_act_d = mode_act_q;
    slow_d     = slow_q;
    tick_d     = 1'b0;
    wrap_c     = (count_q == m_act_q);

    if (en) begin
      if (wrap_c) begin
        count_d    = '0;
        tick_d     = 1'b1;
        m_act_d    = m;
        mode_act_d = mode;
        // Level decided by the mode that governed the period just ending.
        slow_d     = clkdiv_wrap_level(mode_act_q, slow_q);
      end else begin
        count_d = count_q + CNT_W'(1);
        if (mode_act_q == CLKDIV_PULSE) begin
          slow_d = 1'b0;
        end
      end
    end

`ifdef CLKDIV_PHASE_ALIGN_EN
    // Alignment acts like a local reset and beats a coincident wrap.
    if (align && en) begin
      count_d    = '0;
      slow_d     = 1'b0;
      tick_d     = 1'b0;
      m_act_d    = m;
      mode_act_d = mode;
    end
`endif
  end

  // State register; reset captures the requested divisor and mode.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      count_q    <= '0;
      m_act_q    <= m;
      mode_act_q <= mode;
      slow_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      m_act_q    <= m_act_d;
      mode_act_q <= mode_act_d;
      slow_q     <= slow_d;
      tick_q     <= tick_d;
    end
  end

  assign slow_clock = slow_q;
  assign tick       = tick_q;

endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: N_CH independent clock dividers / tick generators.
//   CLOCK, RESET : rising-edge clock, synchronous active-high reset
//   ALIGN        : phase-align strobe, present only when CLKDIV_PHASE_ALIGN_EN is defined
//   EN           : per-channel count enable
//   M            : per-channel divisor, channel i at M[i*CNT_W +: CNT_W]
//   MODE         : per-channel mode (0 toggle, 1 pulse)
//   SLOW_CLOCK   : per-channel divided output (registered)
//   TICK         : per-channel wrap strobe (registered)
module clock_divider_multi
  import clkdiv_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = CLKDIV_CNT_W
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
`ifdef CLKDIV_PHASE_ALIGN_EN
  input  logic                  ALIGN,
`endif
  input  logic [N_CH-1:0]       EN,
  input  logic [N_CH*CNT_W-1:0] M,
  input  logic [N_CH-1:0]       MODE,
  output logic [N_CH-1:0]       SLOW_CLOCK,
  output logic [N_CH-1:0]       TICK
);

  // One channel per slice; only CLOCK, RESET and ALIGN are shared.
  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    clkdiv_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .CLOCK      (CLOCK),
      .RESET      (RESET),
`ifdef CLKDIV_PHASE_ALIGN_EN
      .align      (ALIGN),
`endif
      .en         (EN[i]),
      .m          (M[i*CNT_W +: CNT_W]),
      .mode       (MODE[i]),
      .slow_clock (SLOW_CLOCK[i]),
      .tick       (TICK[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed, table-driven bench for clock_divider_multi.
// Expected waveforms are written as strings, one character per cycle after the
// stimulating edge ('1' high, '0' low).
module tb_clock_divider_multi;

  localparam int N_CH  = 4;
  localparam int CNT_W = 32;

  logic                  CLOCK = 1'b0;
  logic                  RESET;
`ifdef CLKDIV_PHASE_ALIGN_EN
  logic                  ALIGN = 1'b0;
`endif
  logic [N_CH-1:0]       EN;
  logic [N_CH*CNT_W-1:0] M;
  logic [N_CH-1:0]       MODE;
  logic [N_CH-1:0]       SLOW_CLOCK;
  logic [N_CH-1:0]       TICK;

  int checks = 0;
  int errors = 0;

  clock_divider_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .CLOCK      (CLOCK),
    .RESET      (RESET),
`ifdef CLKDIV_PHASE_ALIGN_EN
    .ALIGN      (ALIGN),
`endif
    .EN         (EN),
    .M          (M),
    .MODE       (MODE),
    .SLOW_CLOCK (SLOW_CLOCK),
    .TICK       (TICK)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    int          ch;
    logic        mode;
    logic [31:0] m;
    int          n;
    logic [31:0] slow;
    logic [31:0] tick;
  } vec_t;

  localparam int NVEC = 6;
  vec_t vecs [NVEC];

  function automatic logic [31:0] pat(input string s);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[i] = (s.getc(i) == 8'h31);
    return r;
  endfunction

  task automatic set_vec(input int idx, input int ch, input logic mode, input logic [31:0] m,
                         input string s, input string t);
    vecs[idx].ch   = ch;
    vecs[idx].mode = mode;
    vecs[idx].m    = m;
    vecs[idx].n    = s.len();
    vecs[idx].slow = pat(s);
    vecs[idx].tick = pat(t);
  endtask

  task automatic step();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Step through a pattern on one channel, checking SLOW_CLOCK and TICK each cycle.
  task automatic run_ch(input string tag, input int ch, input string s, input string t);
    for (int i = 0; i < s.len(); i++) begin
      step();
      check($sformatf("%s slow c%0d", tag, i + 1), 32'(SLOW_CLOCK[ch]), 32'(s.getc(i) == 8'h31));
      check($sformatf("%s tick c%0d", tag, i + 1), 32'(TICK[ch]), 32'(t.getc(i) == 8'h31));
    end
  endtask

  task automatic do_reset(input string tag);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check({tag, " rst slow"}, 32'(SLOW_CLOCK), 32'd0);
    check({tag, " rst tick"}, 32'(TICK), 32'd0);
  endtask

  initial begin
    set_vec(0, 0, 1'b0, 32'd4, "00001111100000111110", "00001000010000100001");
    set_vec(1, 1, 1'b1, 32'd2, "001001001",            "001001001");
    set_vec(2, 2, 1'b1, 32'd0, "111111",               "111111");
    set_vec(3, 3, 1'b0, 32'd0, "10101010",             "11111111");
    set_vec(4, 0, 1'b0, 32'd1, "011001100110",         "010101010101");
    set_vec(5, 1, 1'b1, 32'd3, "00010001",             "00010001");

    RESET = 1'b1;
    EN    = '0;
    M     = '0;
    MODE  = '0;
    do_reset("init");

    // Table: reset, enable one channel, compare the waveform; idle channels stay low.
    for (int v = 0; v < NVEC; v++) begin
      M[vecs[v].ch*CNT_W +: CNT_W] = vecs[v].m;
      MODE[vecs[v].ch]             = vecs[v].mode;
      EN = '0;
      do_reset($sformatf("v%0d", v));
      EN[vecs[v].ch] = 1'b1;
      for (int i = 0; i < vecs[v].n; i++) begin
        step();
        check($sformatf("v%0d slow c%0d", v, i + 1), 32'(SLOW_CLOCK[vecs[v].ch]), 32'(vecs[v].slow[i]));
        check($sformatf("v%0d tick c%0d", v, i + 1), 32'(TICK[vecs[v].ch]), 32'(vecs[v].tick[i]));
      end
      check($sformatf("v%0d idle slow", v), 32'(SLOW_CLOCK & ~EN), 32'd0);
      check($sformatf("v%0d idle tick", v), 32'(TICK & ~EN), 32'd0);
      EN = '0;
    end

    // Shadowed divisor: M drops 9 -> 1 at COUNT=3; current half-period still runs 10.
    M[2*CNT_W +: CNT_W] = 32'd9;
    MODE = '0;
    do_reset("shadow");
    EN = 4'b0100;
    run_ch("shadow_a", 2, "000", "000");
    M[2*CNT_W +: CNT_W] = 32'd1;
    run_ch("shadow_b", 2, "0000001100110", "0000001010101");
    EN = '0;

    // Enable gating: 7 disabled cycles stretch the period by 7.
    M[3*CNT_W +: CNT_W] = 32'd3;
    do_reset("gate");
    EN = 4'b1000;
    run_ch("gate_a", 3, "00", "00");
    EN = '0;
    run_ch("gate_off", 3, "0000000", "0000000");
    EN = 4'b1000;
    run_ch("gate_b", 3, "011110", "010001");
    EN = '0;

    // Mode switch toggle -> pulse at a rising wrap, then pulse -> toggle.
    M[0 +: CNT_W] = 32'd2;
    MODE = '0;
    do_reset("mode");
    EN = 4'b0001;
    run_ch("mode_a", 0, "0011100", "0010010");
    MODE[0] = 1'b1;
    run_ch("mode_b", 0, "01001", "01001");
    MODE[0] = 1'b0;
    run_ch("mode_c", 0, "001110", "001001");
    EN = '0;

    // Mid-operation reset while all channels are high at COUNT=2; new M=5 captured.
    for (int c = 0; c < N_CH; c++) M[c*CNT_W +: CNT_W] = 32'd2;
    MODE = '0;
    do_reset("mid");
    EN = '1;
    for (int i = 0; i < 5; i++) step();
    check("mid pre slow", 32'(SLOW_CLOCK), 32'hF);
    check("mid pre tick", 32'(TICK), 32'h0);
    for (int c = 0; c < N_CH; c++) M[c*CNT_W +: CNT_W] = 32'd5;
    do_reset("mid");
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("mid post slow c%0d", i), 32'(SLOW_CLOCK), (i == 6) ? 32'hF : 32'h0);
      check($sformatf("mid post tick c%0d", i), 32'(TICK), (i == 6) ? 32'hF : 32'h0);
    end
    EN = '0;

`ifdef CLKDIV_PHASE_ALIGN_EN
    // Phase alignment: ch0 M=3 and ch1 M=7 out of phase; ch2 disabled during ALIGN.
    M = '0;
    M[0*CNT_W +: CNT_W] = 32'd3;
    M[1*CNT_W +: CNT_W] = 32'd7;
    M[2*CNT_W +: CNT_W] = 32'd5;
    MODE = '0;
    do_reset("align");
    EN = 4'b0101;
    for (int i = 0; i < 3; i++) step();
    EN = 4'b0111;
    for (int i = 0; i < 7; i++) step();
    ALIGN = 1'b1;
    EN    = 4'b0011;
    step();
    ALIGN = 1'b0;
    EN    = 4'b0111;
    check("align slow01", 32'(SLOW_CLOCK[1:0]), 32'd0);
    check("align tick01", 32'(TICK[1:0]), 32'd0);
    check("align slow2 held", 32'(SLOW_CLOCK[2]), 32'd1);
    check("align tick2", 32'(TICK[2]), 32'd0);
    begin
      string s0, t0, s1, t1;
      s0 = "0001111000011110";
      t0 = "0001000100010001";
      s1 = "0000000111111110";
      t1 = "0000000100000001";
      for (int j = 0; j < 16; j++) begin
        step();
        check($sformatf("align ch0 slow j%0d", j + 1), 32'(SLOW_CLOCK[0]), 32'(s0.getc(j) == 8'h31));
        check($sformatf("align ch0 tick j%0d", j + 1), 32'(TICK[0]), 32'(t0.getc(j) == 8'h31));
        check($sformatf("align ch1 slow j%0d", j + 1), 32'(SLOW_CLOCK[1]), 32'(s1.getc(j) == 8'h31));
        check($sformatf("align ch1 tick j%0d", j + 1), 32'(TICK[1]), 32'(t1.getc(j) == 8'h31));
        if (j == 0) begin
          check("align ch2 slow j1", 32'(SLOW_CLOCK[2]), 32'd1);
          check("align ch2 tick j1", 32'(TICK[2]), 32'd0);
        end
        if (j == 1) begin
          check("align ch2 slow j2", 32'(SLOW_CLOCK[2]), 32'd0);
          check("align ch2 tick j2", 32'(TICK[2]), 32'd1);
        end
      end
    end
    EN = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
